// File: rtl/wb_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// The state encodings double as the one-hot grant vector.
package wb_arbiter_2m_pkg;

    localparam int unsigned DefAdrW    = 32;
    localparam int unsigned DefDatW    = 32;
    localparam int unsigned DefSelW    = 2;
    localparam int unsigned DefTimeout = 16;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    // Round-robin pick: on a tie the master that did not own the bus last wins.
    function automatic state_e pick_owner(input logic req0, input logic req1,
                                          input logic last_gnt);
        state_e owner;
        owner = StIdle;
        if (req0 && req1) begin
            owner = last_gnt ? StOwn0 : StOwn1;
        end else if (req0) begin
            owner = StOwn0;
        end else if (req1) begin
            owner = StOwn1;
        end
        return owner;
    endfunction

endpackage

// File: rtl/wb_arbiter_2m_watchdog.sv
// Per-transfer watchdog: pulses expire when a strobed transfer waits
// TIMEOUT cycles without an ack. Clears on ack, expire, idle strobe or clr.
module wb_arbiter_2m_watchdog
    import wb_arbiter_2m_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    input  logic ack,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Ack in the terminal cycle wins over the timeout.
    assign expire = busy & ~ack & (cnt_q == TermCnt);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr || !busy || ack || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave classic Wishbone arbiter with round-robin grant
// locked for the whole bus cycle and a per-transfer ack watchdog.
module wb_arbiter_2m
    import wb_arbiter_2m_pkg::*;
#(
    parameter int unsigned ADR_W   = DefAdrW,
    parameter int unsigned DAT_W   = DefDatW,
    parameter int unsigned SEL_W   = DefSelW,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic             m0_we_i,
    input  logic             m0_tga_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic             m1_we_i,
    input  logic             m1_tga_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic             s_we_o,
    output logic             s_tga_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,

    output logic [1:0]       gnt_o
);

    state_e state_q;
    state_e state_d;
    logic   last_gnt_q;
    logic   last_gnt_d;

    logic own0;
    logic own1;
    logic busy;
    logic expire;

    assign own0 = (state_q == StOwn0);
    assign own1 = (state_q == StOwn1);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            StIdle: begin
                state_d = pick_owner(m0_cyc_i, m1_cyc_i, last_gnt_q);
            end
            StOwn0: begin
                last_gnt_d = 1'b0;
                if (!m0_cyc_i) begin
                    state_d = pick_owner(1'b0, m1_cyc_i, last_gnt_q);
                end
            end
            StOwn1: begin
                last_gnt_d = 1'b1;
                if (!m1_cyc_i) begin
                    state_d = pick_owner(m0_cyc_i, 1'b0, last_gnt_q);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign busy = (own0 & m0_stb_i & m0_cyc_i) | (own1 & m1_stb_i & m1_cyc_i);

    wb_arbiter_2m_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clr    (state_d != state_q),
        .busy   (busy),
        .ack    (s_ack_i),
        .expire (expire)
    );

    // Slave side is driven only by the current owner; idle drives all zeros.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_tga_o = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        case (state_q)
            StOwn0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_we_o  = m0_we_i;
                s_tga_o = m0_tga_i;
                s_sel_o = m0_sel_i;
                s_stb_o = m0_stb_i & ~expire;
                s_cyc_o = m0_cyc_i;
            end
            StOwn1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_we_o  = m1_we_i;
                s_tga_o = m1_tga_i;
                s_sel_o = m1_sel_i;
                s_stb_o = m1_stb_i & ~expire;
                s_cyc_o = m1_cyc_i;
            end
            default: begin
            end
        endcase
    end

    // A transfer caught by reset is aborted silently.
    assign m0_ack_o = s_ack_i & own0 & m0_cyc_i & m0_stb_i & ~wb_rst_i;
    assign m1_ack_o = s_ack_i & own1 & m1_cyc_i & m1_stb_i & ~wb_rst_i;
    assign m0_err_o = expire & own0 & ~wb_rst_i;
    assign m1_err_o = expire & own1 & ~wb_rst_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign gnt_o = state_q;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: reset, round-robin ties, grant lock,
// watchdog timeout, ack/timeout race and mid-transfer reset.
module tb_wb_arbiter_2m;

    typedef struct {
        int unsigned m;
        logic [31:0] adr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat;
    logic        m0_we, m1_we, m0_tga, m1_tga;
    logic [1:0]  m0_sel, m1_sel;
    logic        m0_stb, m1_stb, m0_cyc, m1_cyc;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_we_o, s_tga_o, s_stb_o, s_cyc_o;
    logic [1:0]  s_sel_o;
    logic [31:0] s_dat;
    logic        s_ack;
    logic [1:0]  gnt_o;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    wb_arbiter_2m #(
        .ADR_W   (32),
        .DAT_W   (32),
        .SEL_W   (2),
        .TIMEOUT (16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_adr_i (m0_adr),
        .m0_dat_i (m0_dat),
        .m0_we_i  (m0_we),
        .m0_tga_i (m0_tga),
        .m0_sel_i (m0_sel),
        .m0_stb_i (m0_stb),
        .m0_cyc_i (m0_cyc),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr),
        .m1_dat_i (m1_dat),
        .m1_we_i  (m1_we),
        .m1_tga_i (m1_tga),
        .m1_sel_i (m1_sel),
        .m1_stb_i (m1_stb),
        .m1_cyc_i (m1_cyc),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_we_o   (s_we_o),
        .s_tga_o  (s_tga_o),
        .s_sel_o  (s_sel_o),
        .s_stb_o  (s_stb_o),
        .s_cyc_o  (s_cyc_o),
        .s_dat_i  (s_dat),
        .s_ack_i  (s_ack),
        .gnt_o    (gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic [31:0] adr);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_adr = adr; m0_dat = adr ^ 32'hA5A5_0000;
            m0_we = 1'b0; m0_tga = 1'b0; m0_sel = 2'b11;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_adr = adr; m1_dat = adr ^ 32'h5A5A_0000;
            m1_we = 1'b0; m1_tga = 1'b1; m1_sel = 2'b11;
        end
    endtask

    // One-cycle slave ack; the scoreboard says which master and address to expect.
    task automatic slave_ack();
        exp_t        e;
        logic [31:0] d;
        d = $urandom;
        s_dat = d;
        s_ack = 1'b1;
        #1;
        e = sb.pop_front();
        chk("ack_m0", 32'(m0_ack_o), 32'(e.m == 0));
        chk("ack_m1", 32'(m1_ack_o), 32'(e.m == 1));
        chk("ack_adr", s_adr_o, e.adr);
        chk("ack_tga", 32'(s_tga_o), e.m);
        chk("ack_rdat", (e.m == 0) ? m0_dat_o : m1_dat_o, d);
        chk("ack_no_err", 32'({m0_err_o, m1_err_o}), 32'd0);
        step();
        s_ack = 1'b0;
    endtask

    // Called in the first strobed cycle of master m with no ack coming.
    task automatic watch_timeout(input int m);
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk("to_err_m0", 32'(m0_err_o), 32'(m == 0 && k == 16));
            chk("to_err_m1", 32'(m1_err_o), 32'(m == 1 && k == 16));
            chk("to_stb", 32'(s_stb_o), 32'(k != 16));
            step();
        end
        #1;
        chk("to_one_shot", 32'({m0_err_o, m1_err_o}), 32'd0);
    endtask

    task automatic tie_round();
        set_m(0, 1'b1, 1'b1, 32'h10);
        set_m(1, 1'b1, 1'b1, 32'h20);
        sb.push_back('{m: 0, adr: 32'h10});
        sb.push_back('{m: 1, adr: 32'h20});
        step();
        #1;
        chk("tie_first_gnt", 32'(gnt_o), 32'h1);
        slave_ack();
        set_m(0, 1'b0, 1'b0, 32'h0);
        step();
        #1;
        chk("tie_second_gnt", 32'(gnt_o), 32'h2);
        slave_ack();
        set_m(1, 1'b0, 1'b0, 32'h0);
        step();
        #1;
        chk("tie_idle_gnt", 32'(gnt_o), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        s_ack = 1'b0;
        s_dat = '0;
        set_m(0, 1'b1, 1'b0, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h0);

        // Reset held with both requesting.
        repeat (3) step();
        #1;
        chk("rst_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_acks", 32'({m0_ack_o, m1_ack_o}), 32'd0);
        chk("rst_adr", s_adr_o, 32'd0);
        rst = 1'b0;
        step();
        #1;
        chk("rel_gnt", 32'(gnt_o), 32'h1);
        chk("rel_cyc", 32'(s_cyc_o), 32'd1);
        set_m(0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("own0_drop_cyc", 32'(s_cyc_o), 32'd0);
        step();
        #1;
        chk("handover_gnt", 32'(gnt_o), 32'h2);
        set_m(1, 1'b0, 1'b0, 32'h0);
        step();
        #1;
        chk("idle_gnt", 32'(gnt_o), 32'd0);
        chk("idle_adr", s_adr_o, 32'd0);

        // Ties: m0 wins both times since m1 was the last owner.
        tie_round();
        tie_round();

        // Grant lock: m1 does four strobes under one cyc while m0 waits.
        set_m(1, 1'b1, 1'b1, 32'h100);
        step();
        set_m(0, 1'b1, 1'b1, 32'h99);
        for (int k = 0; k < 4; k++) begin
            set_m(1, 1'b1, 1'b1, 32'h100 + 32'(4 * k));
            sb.push_back('{m: 1, adr: 32'h100 + 32'(4 * k)});
            slave_ack();
        end
        set_m(1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("lock_gnt_hold", 32'(gnt_o), 32'h2);
        step();
        #1;
        chk("lock_handover", 32'(gnt_o), 32'h1);
        sb.push_back('{m: 0, adr: 32'h99});
        slave_ack();
        set_m(0, 1'b0, 1'b0, 32'h0);
        step();
        #1;
        chk("lock_idle", 32'(gnt_o), 32'd0);

        // Timeout with no ack from the slave.
        set_m(0, 1'b1, 1'b1, 32'h40);
        step();
        watch_timeout(0);
        #1;
        chk("to_grant_kept", 32'(gnt_o), 32'h1);
        set_m(0, 1'b0, 1'b0, 32'h0);
        step();
        #1;
        chk("to_idle", 32'(gnt_o), 32'd0);

        // Ack lands in the cycle err would fire; count must restart from zero.
        set_m(0, 1'b1, 1'b1, 32'h50);
        step();
        repeat (15) begin
            #1;
            chk("race_pre_err", 32'(m0_err_o), 32'd0);
            step();
        end
        sb.push_back('{m: 0, adr: 32'h50});
        slave_ack();
        watch_timeout(0);
        set_m(0, 1'b0, 1'b0, 32'h0);
        step();
        #1;
        chk("race_idle", 32'(gnt_o), 32'd0);

        // Reset five cycles into an m1 slave wait.
        set_m(1, 1'b1, 1'b1, 32'h60);
        step();
        repeat (5) step();
        #1;
        chk("mid_pre_cyc", 32'(s_cyc_o), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_cyc", 32'(s_cyc_o), 32'd0);
        chk("mid_gnt", 32'(gnt_o), 32'd0);
        chk("mid_ack", 32'(m1_ack_o), 32'd0);
        chk("mid_err", 32'(m1_err_o), 32'd0);
        set_m(1, 1'b0, 1'b0, 32'h0);
        step();
        #1;
        chk("mid_after_gnt", 32'(gnt_o), 32'd0);
        chk("mid_after_err", 32'({m0_err_o, m1_err_o}), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter for the muskoka SoC.
- Shares the single on-chip test RAM slave port between the moxie instruction-fetch master (m0) and the data master (m1).
- Round-robin arbitration; the grant is locked for the whole bus cycle (cyc).
- A per-transfer watchdog terminates a master with err if the slave never acks, so a missing or unmapped ack cannot hang the core.

Parameters:
- ADR_W, 32, address width on all ports.
- DAT_W, 32, data width on all ports.
- SEL_W, 2, byte-select width (matches the RAM slave's select port).
- TIMEOUT, 16, cycles without ack before err is raised; legal range 2..255.

Ports:
- wb_clk_i  in  1  system clock; all state on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- m0_adr_i, m1_adr_i  in  ADR_W  master address.
- m0_dat_i, m1_dat_i  in  DAT_W  master write data.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_tga_i, m1_tga_i  in  1  address tag, passed through.
- m0_sel_i, m1_sel_i  in  SEL_W  byte selects.
- m0_stb_i, m1_stb_i  in  1  strobe.
- m0_cyc_i, m1_cyc_i  in  1  cycle / bus request.
- m0_dat_o, m1_dat_o  out  DAT_W  read data (s_dat_i broadcast to both).
- m0_ack_o, m1_ack_o  out  1  gated ack.
- m0_err_o, m1_err_o  out  1  timeout error pulse.
- s_adr_o  out  ADR_W  muxed slave address.
- s_dat_o  out  DAT_W  muxed slave write data.
- s_we_o, s_tga_o, s_stb_o, s_cyc_o  out  1 each  muxed slave controls.
- s_sel_o  out  SEL_W  muxed slave byte selects.
- s_dat_i  in  DAT_W  slave read data.
- s_ack_i  in  1  slave ack (may be combinational).
- gnt_o  out  2  one-hot current owner; 00 when idle.

Behaviour:
- States: IDLE, OWN0, OWN1; one-hot or 2-bit encoding. Register last_gnt (1 bit).
- Reset (wb_rst_i=1 at edge):
  - state=IDLE, last_gnt=1 so m0 wins the first tie, watchdog=0.
  - All s_* outputs 0, all ack/err outputs 0, gnt_o=00.
  - Reset asserted mid-transfer aborts it: s_cyc_o=0 from the next edge, and no ack or err is issued for the aborted transfer.
- IDLE:
  - Only m0_cyc → OWN0. Only m1_cyc → OWN1.
  - Both → OWN of the master not equal to last_gnt.
  - Arbitration latency is one cycle from cyc rising to s_cyc_o.
- OWNn:
  - s_adr/dat/we/tga/sel/stb = mn_* (combinational mux).
  - s_cyc_o = mn_cyc_i; gnt_o[n]=1; last_gnt <= n.
  - Exit when mn_cyc_i=0: go to OWN(other) if the other master's cyc=1 (zero idle cycles), else IDLE.
  - The other master's cyc never preempts the owner.
- Outputs in IDLE: all s_* outputs are 0 (not the last owner's values).
- Ack gating:
  - mn_ack_o = s_ack_i & OWNn & mn_cyc_i & mn_stb_i.
  - The non-owner's ack and err are always 0.
  - Read data is valid only alongside ack.
- Watchdog:
  - Counts in OWNn while mn_stb_i & mn_cyc_i & !s_ack_i.
  - Clears on ack, on err, when stb=0, and on any state change.
  - When count == TIMEOUT-1 and still no ack: mn_err_o=1 for exactly that cycle, s_stb_o forced 0 in that cycle, counter clears.
  - The master must then drop cyc; the arbiter keeps the grant until it does.
- Simultaneous events:
  - Ack in the same cycle as terminal count → ack wins, no err.
  - Both cyc rising in the same cycle in IDLE → round-robin rule above.
  - Owner drops cyc while the other requests → handover on the next edge.
- Counter width is clog2(TIMEOUT); no wrap. Saturation cannot occur because the counter clears at the terminal count.
- Pipelined/burst Wishbone is not supported: classic single cycles only, but back-to-back stb under one cyc is allowed and keeps the grant.

Decomposition:
- Shared include muskoka_wb_defs.vh holds:
  - state encodings ST_IDLE, ST_OWN0, ST_OWN1;
  - the default WB widths (ADR 32, DAT 32, SEL 2);
  - TIMEOUT default.
- One natural sub-module, wb_watchdog (inputs: clk, rst, clr, busy, ack; output: expire pulse; parameter TIMEOUT). It is instantiated once and fed the owner's stb/cyc.
- The arbiter FSM and output mux stay in wb_arbiter_2m.

Test Plan:
- Reset check: hold wb_rst_i for 3 cycles with both cyc=1 → s_cyc_o=0, gnt_o=00, acks 0. First edge after release → gnt_o=01.
- Tie and round-robin: m0 and m1 raise cyc together and each does a 1-cycle-ack read, with m0 at adr 0x10 and m1 at adr 0x20.
  - Expected order: m0 served first (s_adr_o=0x10), then m1 (0x20) with zero idle cycles between.
  - Repeat the tie → m0 first again, since last_gnt=1.
- Grant lock: m1 owns with 4 back-to-back stb under one cyc while m0_cyc=1 throughout → all 4 s_adr_o values come from m1, m0_ack_o stays 0, and m0 is granted the cycle after m1_cyc drops.
- Timeout: slave ack tied 0 and m0 strobes → m0_err_o pulses exactly at cycle 16 of stb (TIMEOUT=16), s_stb_o=0 in that cycle, m1_err_o=0. m0 drops cyc → IDLE.
- Ack/timeout race: ack first asserted on count 15 (the cycle err would fire) → m0_ack_o=1, m0_err_o=0, counter cleared.
- Mid-transfer reset: wb_rst_i pulsed during an m1 read that is 5 cycles into a slave wait → next cycle s_cyc_o=0, no ack or err to m1, state IDLE.
